// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the FPGA debug path (parser -> response queue ->
// uart_tx). It holds the drain FSM state type of tx_response_queue and a
// helper that derives the queue pointer width from the queue depth.
// ---------------------------------------------------------------------------
package dbg_pkg;

   // The drain FSM hands one byte at a time to uart_tx.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } tx_q_state_e;

   // Pointer width for a power-of-two queue depth. Pointers of this width wrap
   // from DEPTH-1 back to 0 on their own.
   function automatic int ptrWidth(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/tx_response_queue.sv
// ---------------------------------------------------------------------------
// tx_response_queue
// Response byte queue that sits between command_parser and uart_tx. The
// parser can burst a multi-byte reply into a circular store. A small FSM then
// drains the store one byte at a time through the tx_start/tx_busy handshake
// of uart_tx.
//
// Ports
//   clk, rst_n      : single clock, asynchronous active-low reset
//   push_data_i     : byte from the parser
//   push_valid_i    : push request; the byte is dropped when the queue is full
//   push_ready_o    : queue not full (combinational from the occupancy)
//   tx_data_o       : byte to uart_tx, held from START until the next pop
//   tx_start        : one-cycle send pulse to uart_tx
//   tx_busy         : uart_tx busy
//   level_o         : current occupancy, 0..DEPTH
//   overflow_o      : sticky flag for a dropped push
//   clr_overflow_i  : clears overflow_o; a new overflow in the same cycle wins
// ---------------------------------------------------------------------------
module tx_response_queue
   import dbg_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      push_data_i,
   input  logic                       push_valid_i,
   output logic                       push_ready_o,
   output logic [DATA_WIDTH-1:0]      tx_data_o,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   input  logic                       clr_overflow_i
);

   localparam int PW = ptrWidth(DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_writePtr;
   logic [PW-1:0]         r_readPtr;
   logic [LW-1:0]         r_count;
   logic [TW-1:0]         r_timer;
   logic [DATA_WIDTH-1:0] r_txData;
   logic                  r_txStart;
   logic                  r_overflow;
   tx_q_state_e           r_state;
   tx_q_state_e           w_nextState;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_pop;

   // A full queue refuses pushes. A pop in the same cycle does not free a
   // slot early, so a push while full is always dropped.
   assign w_full  = (r_count == LW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = push_valid_i & ~w_full;
   assign w_drop  = push_valid_i & w_full;

   assign push_ready_o = ~w_full;
   assign tx_data_o    = r_txData;
   assign tx_start     = r_txStart;
   assign level_o      = r_count;
   assign overflow_o   = r_overflow;

   // Storage array. It has no reset: entries are only read after being
   // written, and a reset flush only has to clear the pointers and the count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_writePtr] <= push_data_i;
      end
   end

   // The drain FSM pops only from IDLE, and only while uart_tx is idle. This
   // way tx_start can never land on a busy UART. WAIT_BUSY gives up after
   // BUSY_TIMEOUT cycles so that a UART that never answers cannot deadlock
   // the queue.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty && !tx_busy) begin
               w_pop       = 1'b1;
               w_nextState = ST_START;
            end
         end
         ST_START: begin
            w_nextState = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               w_nextState = ST_WAIT_DONE;
            end else if (r_timer == '0) begin
               w_nextState = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // The state register and the busy timeout. The timer is loaded in START
   // with BUSY_TIMEOUT-1. WAIT_BUSY therefore lasts BUSY_TIMEOUT cycles, and
   // it leaves on the cycle that sees the timer at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_START) begin
            r_timer <= TW'(BUSY_TIMEOUT - 1);
         end else if (r_state == ST_WAIT_BUSY && r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
         end
      end
   end

   // Pointers and occupancy. When a push and a pop happen in the same cycle,
   // the count stays the same. A pop never happens on an empty queue, so the
   // count cannot underflow. A push never happens on a full queue, so the
   // count cannot overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_writePtr <= '0;
         r_readPtr  <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_writePtr <= r_writePtr + PW'(1);
         end
         if (w_pop) begin
            r_readPtr <= r_readPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output registers. The byte is captured on the pop itself, so it is
   // stable from the START cycle until the next pop. tx_start is high during
   // the cycle right after a pop, which is exactly the START state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txData   <= '0;
         r_txStart  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_txStart <= w_pop;
         if (w_pop) begin
            r_txData <= r_mem[r_readPtr];
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow_i) begin
            r_overflow <= 1'b0;
         end
      end
   end

endmodule
